// File: rtl/ttm4_pkg.sv
// Shared TTM4 definitions: mnemonic codes, opcode encodings, loader error codes and states.
// The VERIFY state exists only when PROG_VERIFY_EN is defined.
package ttm4_pkg;

  localparam int unsigned INSN_W = 11;

  localparam logic [3:0] MN_ADD  = 4'd0;
  localparam logic [3:0] MN_AND  = 4'd1;
  localparam logic [3:0] MN_OR   = 4'd2;
  localparam logic [3:0] MN_XOR  = 4'd3;
  localparam logic [3:0] MN_JMP  = 4'd4;
  localparam logic [3:0] MN_JNC  = 4'd5;
  localparam logic [3:0] MN_JZ   = 4'd6;
  localparam logic [3:0] MN_SKIP = 4'd7;

  localparam logic [4:0] OP_ADD  = 5'b10111;
  localparam logic [4:0] OP_AND  = 5'b10000;
  localparam logic [4:0] OP_OR   = 5'b10010;
  localparam logic [4:0] OP_XOR  = 5'b00001;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_JNC  = 5'b01010;
  localparam logic [4:0] OP_JZ   = 5'b01011;
  localparam logic [4:0] OP_SKIP = 5'b01000;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_VERIFY   = 2'd3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccept = 3'd1,
    StWrite  = 3'd2,
`ifdef PROG_VERIFY_EN
    StVerify = 3'd3,
`endif
    StFin    = 3'd4
  } loaderStateE;

endpackage

// File: rtl/ttm4_insn_encoder.sv
// Combinational mnemonic-to-instruction-word encoder with an illegal flag.
// Shared between the program loader and the emulator test host.
module ttm4_insn_encoder
  import ttm4_pkg::*;
(
  input  logic [3:0]        mnem_i,
  input  logic [2:0]        lr_i,
  input  logic [2:0]        sr_i,
  output logic [INSN_W-1:0] word_o,
  output logic              illegal_o
);

  logic [4:0] op;
  logic       aluOp;
  logic       illegal;

  always_comb begin
    op      = '0;
    aluOp   = 1'b0;
    illegal = 1'b0;
    case (mnem_i)
      MN_ADD:  begin op = OP_ADD; aluOp = 1'b1; end
      MN_AND:  begin op = OP_AND; aluOp = 1'b1; end
      MN_OR:   begin op = OP_OR;  aluOp = 1'b1; end
      MN_XOR:  begin op = OP_XOR; aluOp = 1'b1; end
      MN_JMP:  op = OP_JMP;
      MN_JNC:  op = OP_JNC;
      MN_JZ:   op = OP_JZ;
      MN_SKIP: op = OP_SKIP;
      default: illegal = 1'b1;
    endcase
    // r0/r1 are not addressable by ALU ops
    if (aluOp && ((lr_i < 3'd2) || (sr_i < 3'd2))) begin
      illegal = 1'b1;
    end
    illegal_o = illegal;
    if (illegal) begin
      word_o = '0;
    end else if (aluOp) begin
      word_o = {op, lr_i, sr_i};
    end else begin
      word_o = {op, 6'b000000};
    end
  end

endmodule

// File: rtl/ttm4_program_loader.sv
// Sequential program-memory loader: encodes handshaked mnemonics and writes them from address 0.
// Defining PROG_VERIFY_EN adds a read-back compare after every write.
module ttm4_program_loader
  import ttm4_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        IN_MNEM,
  input  logic [2:0]        IN_LR,
  input  logic [2:0]        IN_SR,
  input  logic              IN_LAST,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [INSN_W-1:0] MEM_WDATA,
  input  logic [INSN_W-1:0] MEM_RDATA,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        ERR_CODE
);

  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

  loaderStateE       stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              fullQ, fullD;
  logic [INSN_W-1:0] wordQ, wordD;
  logic              lastQ, lastD;
  logic              doneQ, doneD;
  logic              errQ, errD;
  logic [1:0]        errCodeQ, errCodeD;
  logic              advance;

  logic [INSN_W-1:0] encWord;
  logic              encIllegal;

  ttm4_insn_encoder uEncoder (
    .mnem_i    (IN_MNEM),
    .lr_i      (IN_LR),
    .sr_i      (IN_SR),
    .word_o    (encWord),
    .illegal_o (encIllegal)
  );

`ifndef PROG_VERIFY_EN
  logic unusedRdata;
  assign unusedRdata = ^MEM_RDATA;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateQ   <= StIdle;
      addrQ    <= '0;
      fullQ    <= 1'b0;
      wordQ    <= '0;
      lastQ    <= 1'b0;
      doneQ    <= 1'b0;
      errQ     <= 1'b0;
      errCodeQ <= ERR_NONE;
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      fullQ    <= fullD;
      wordQ    <= wordD;
      lastQ    <= lastD;
      doneQ    <= doneD;
      errQ     <= errD;
      errCodeQ <= errCodeD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    addrD    = addrQ;
    fullD    = fullQ;
    wordD    = wordQ;
    lastD    = lastQ;
    doneD    = doneQ;
    errD     = errQ;
    errCodeD = errCodeQ;
    advance  = 1'b0;

    case (stateQ)
      StIdle, StFin: begin
        if (START) begin
          addrD    = '0;
          fullD    = 1'b0;
          doneD    = 1'b0;
          errD     = 1'b0;
          errCodeD = ERR_NONE;
          stateD   = StAccept;
        end
      end
      StAccept: begin
        if (IN_VALID) begin
          if (encIllegal) begin
            doneD    = 1'b1;
            errD     = 1'b1;
            errCodeD = ERR_ILLEGAL;
            stateD   = StFin;
          end else if (fullQ) begin
            doneD    = 1'b1;
            errD     = 1'b1;
            errCodeD = ERR_OVERFLOW;
            stateD   = StFin;
          end else begin
            wordD  = encWord;
            lastD  = IN_LAST;
            stateD = StWrite;
          end
        end
      end
      StWrite: begin
`ifdef PROG_VERIFY_EN
        stateD = StVerify;
`else
        advance = 1'b1;
`endif
      end
`ifdef PROG_VERIFY_EN
      StVerify: begin
        if (MEM_RDATA != wordQ) begin
          doneD    = 1'b1;
          errD     = 1'b1;
          errCodeD = ERR_VERIFY;
          stateD   = StFin;
        end else begin
          advance = 1'b1;
        end
      end
`endif
      default: stateD = StIdle;
    endcase

    // The top address is remembered via fullQ instead of wrapping
    if (advance) begin
      if (addrQ == AddrMax) begin
        fullD = 1'b1;
      end else begin
        addrD = addrQ + ADDR_W'(1);
      end
      if (lastQ) begin
        doneD  = 1'b1;
        stateD = StFin;
      end else begin
        stateD = StAccept;
      end
    end
  end

  always_comb begin
    IN_READY = (stateQ == StAccept);
    MEM_WE   = (stateQ == StWrite);
`ifdef PROG_VERIFY_EN
    BUSY     = (stateQ == StAccept) || (stateQ == StWrite) || (stateQ == StVerify);
`else
    BUSY     = (stateQ == StAccept) || (stateQ == StWrite);
`endif
    CPU_HOLD  = BUSY;
    MEM_ADDR  = addrQ;
    MEM_WDATA = wordQ;
    DONE      = doneQ;
    ERR       = errQ;
    ERR_CODE  = errCodeQ;
  end

endmodule

// File: tb/tb_ttm4_program_loader.sv
// Directed bench for ttm4_program_loader with a write scoreboard and a simple memory model.
// Define PROG_VERIFY_EN to also exercise the read-back verify path.
module tb_ttm4_program_loader;
  import ttm4_pkg::*;

  localparam int AW = 4;
`ifdef PROG_VERIFY_EN
  localparam int VerLat = 1;
`else
  localparam int VerLat = 0;
`endif

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          START = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [3:0]    IN_MNEM = '0;
  logic [2:0]    IN_LR = '0;
  logic [2:0]    IN_SR = '0;
  logic          IN_LAST = 1'b0;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [10:0]   MEM_WDATA;
  logic [10:0]   MEM_RDATA;
  logic          CPU_HOLD;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [1:0]    ERR_CODE;

  logic [10:0] mem [16];
  logic        corrupt = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [10:0] data;
  } wrT;
  wrT sb[$];

  ttm4_program_loader #(.ADDR_W(AW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .START     (START),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_MNEM   (IN_MNEM),
    .IN_LR     (IN_LR),
    .IN_SR     (IN_SR),
    .IN_LAST   (IN_LAST),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .CPU_HOLD  (CPU_HOLD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .ERR_CODE  (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
  end

  // Optional fault: bit 0 of address 2 reads back flipped
  assign MEM_RDATA = mem[MEM_ADDR] ^ {10'd0, (corrupt && (MEM_ADDR == 4'd2))};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    wrT e;
    if (nRST && (MEM_WE === 1'b1)) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(MEM_ADDR), 32'(e.addr));
        chk("wr_data", 32'(MEM_WDATA), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic waitReady();
    int n = 0;
    while (IN_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(IN_READY), 32'd1);
  endtask

  task automatic startSession();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic send(input logic [3:0] m, input logic [2:0] lr, input logic [2:0] sr,
                      input logic last);
    waitReady();
    IN_MNEM  = m;
    IN_LR    = lr;
    IN_SR    = sr;
    IN_LAST  = last;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  function automatic logic [31:0] allOuts();
    return 32'({IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    tick();
    tick();
    chk("reset_outputs", allOuts(), 32'd0);
    nRST = 1'b1;
    tick();
    chk("idle_ready", 32'(IN_READY), 32'd0);

    // Single ADD with LAST
    startSession();
    chk("start_ready", 32'(IN_READY), 32'd1);
    chk("start_hold", 32'({CPU_HOLD, BUSY}), 32'b11);
    sb.push_back({4'd0, 11'b10111_010_011});
    send(MN_ADD, 3'd2, 3'd3, 1'b1);
    chk("write_ready_low", 32'(IN_READY), 32'd0);
    repeat (1 + VerLat) tick();
    chk("add_done", 32'({DONE, ERR, CPU_HOLD, BUSY}), 32'b1000);

    // 16 back-to-back JMPs then overflow
    startSession();
    chk("restart_addr", 32'(MEM_ADDR), 32'd0);
    IN_MNEM = MN_JMP;
    IN_LR   = 3'd5;
    IN_SR   = 3'd6;
    IN_LAST = 1'b0;
    for (int i = 0; i < 17; i++) begin
      waitReady();
      if (i < 16) sb.push_back({i[3:0], 5'b01100, 6'b000000});
      IN_VALID = 1'b1;
      tick();
      if (i < 16) chk("b2b_ready_low", 32'(IN_READY), 32'd0);
    end
    IN_VALID = 1'b0;
    chk("ovf_status", 32'({DONE, ERR, ERR_CODE, BUSY}), 32'b1_1_10_0);
    chk("ovf_addr_hold", 32'(MEM_ADDR), 32'd15);

    // Illegal field: AND with LR=1
    startSession();
    send(MN_AND, 3'd1, 3'd3, 1'b1);
    chk("ill_field", 32'({DONE, ERR, ERR_CODE, MEM_WE, BUSY}), 32'b1_1_01_0_0);

    // Illegal mnemonic, then a clean restart
    startSession();
    send(4'd9, 3'd2, 3'd2, 1'b0);
    chk("ill_mnem", 32'({DONE, ERR, ERR_CODE}), 32'b1_1_01);
    startSession();
    chk("restart_clear", 32'({DONE, ERR, ERR_CODE, MEM_ADDR, IN_READY}), 32'b0_0_00_0000_1);
    sb.push_back({4'd0, 5'b01000, 6'b000000});
    send(MN_SKIP, 3'd7, 3'd7, 1'b1);
    repeat (1 + VerLat) tick();
    chk("skip_done", 32'({DONE, ERR}), 32'b10);

    // Reset during WRITE
    startSession();
    sb.push_back({4'd0, 5'b10010, 3'd3, 3'd4});
    send(MN_OR, 3'd3, 3'd4, 1'b0);
    chk("pre_reset_we", 32'(MEM_WE), 32'd1);
    #2 nRST = 1'b0;
    #1 chk("async_reset_outputs", allOuts(), 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    startSession();
    chk("post_reset_ready", 32'(IN_READY), 32'd1);
    sb.push_back({4'd0, 5'b00001, 3'd2, 3'd2});
    send(MN_XOR, 3'd2, 3'd2, 1'b1);
    repeat (1 + VerLat) tick();
    chk("post_reset_done", 32'({DONE, ERR, MEM_ADDR}), 32'b1_0_0001);

`ifdef PROG_VERIFY_EN
    // Read-back corrupted at address 2
    corrupt = 1'b1;
    startSession();
    sb.push_back({4'd0, 5'b10111, 3'd2, 3'd3});
    send(MN_ADD, 3'd2, 3'd3, 1'b0);
    sb.push_back({4'd1, 5'b10000, 3'd4, 3'd5});
    send(MN_AND, 3'd4, 3'd5, 1'b0);
    waitReady();
    chk("verify_clean", 32'({DONE, ERR, MEM_ADDR}), 32'b0_0_0010);
    sb.push_back({4'd2, 5'b00001, 3'd6, 3'd7});
    send(MN_XOR, 3'd6, 3'd7, 1'b1);
    tick();
    tick();
    chk("verify_err", 32'({DONE, ERR, ERR_CODE}), 32'b1_1_11);
    corrupt = 1'b0;
`endif

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttm4_program_loader.md
# ttm4_program_loader

Writer-side counterpart of the TTM4 instruction decoder. Accepts mnemonic-level instructions over a valid/ready handshake, encodes each into the 11-bit word {OP[4:0], LR[2:0], SR[2:0]} that the decoder consumes, and writes the words sequentially into program memory. The CPU is held off while a load session runs. Sits between the host/debug front end and the program memory.

## Interface
- ADDR_W, 4, program-memory address width (depth 2^ADDR_W words)
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse that opens a load session
- IN_VALID  in  1  mnemonic present
- IN_READY  out  1  loader accepts the mnemonic this cycle
- IN_MNEM  in  4  mnemonic code (package constants)
- IN_LR  in  3  load/output register field
- IN_SR  in  3  store register field
- IN_LAST  in  1  final instruction of the session
- MEM_WE  out  1  program-memory write strobe
- MEM_ADDR  out  ADDR_W  write/readback address
- MEM_WDATA  out  11  encoded word
- MEM_RDATA  in  11  readback data, combinational from MEM_ADDR (used only with verify)
- CPU_HOLD  out  1  CPU held while high
- BUSY  out  1  session in progress
- DONE  out  1  session ended; held until next START
- ERR  out  1  session ended abnormally
- ERR_CODE  out  2  0 none, 1 illegal mnemonic/field, 2 overflow, 3 verify mismatch

## Operation
- States: IDLE, ACCEPT, WRITE, VERIFY (only with macro), FIN.
- IDLE/FIN: START sets the address to 0, clears DONE/ERR/ERR_CODE and moves to ACCEPT. START in any other state is ignored.
- ACCEPT: IN_READY=1. On IN_VALID, capture the encoded word and IN_LAST, then go to WRITE.
- Encoding: ADD(0)→10111; AND(1)→10000; OR(2)→10010; XOR(3)→00001; JMP(4)→01100; JNC(5)→01010; JZ(6)→01011; SKIP(7)→01000.
- ALU ops (codes 0-3): IN_LR and IN_SR must be 2-7. Otherwise the field is illegal.
- Jump and SKIP: LR and SR are forced to 000.
- Codes 8-15 are illegal.
- An illegal input is accepted but not written. Set ERR with code 1 and go to FIN.
- WRITE: MEM_WE=1 for one cycle with MEM_WDATA at MEM_ADDR.
  - Without verify: increment the address, then go to FIN if the word was LAST, else to ACCEPT.
  - With verify: go to VERIFY.
- Overflow: a word accepted after address 2^ADDR_W−1 has been written is not written. Set ERR with code 2 and go to FIN. The address does not wrap.
- FIN: DONE=1, CPU_HOLD=0.
- CPU_HOLD and BUSY are 1 in ACCEPT, WRITE and VERIFY.

## Timing
- Reset values: all outputs 0, state IDLE, address 0. Reset mid-session drops MEM_WE asynchronously. No partial write completes.
- Handshake: a transfer occurs on the edge where IN_VALID & IN_READY. IN_READY is registered (state-decoded) and never depends combinationally on IN_VALID.
- Write latency: MEM_WE is asserted in the cycle after acceptance.
- Throughput: 1 word per 2 cycles, or per 3 cycles with verify.
- START to IN_READY: 1 cycle.
- LAST write to DONE: 1 cycle, or 2 with verify.
- Error detection to DONE/ERR: 1 cycle after acceptance.

## Configuration
- PROG_VERIFY_EN defined: the VERIFY state holds MEM_ADDR on the just-written address with MEM_WE=0 and compares MEM_RDATA to the word.
  - Mismatch: ERR with code 3, go to FIN.
  - Match: increment the address and continue.
- PROG_VERIFY_EN undefined: no VERIFY state, MEM_RDATA is unused, and ERR_CODE 3 never occurs.

## Structure
- Shared package ttm4_pkg holds:
  - mnemonic code constants (MN_ADD…MN_SKIP)
  - the 5-bit OP constants listed above
  - ERR_CODE constants
  - the state enum
  - instruction-word width 11
- One sub-module: ttm4_insn_encoder, combinational. Maps mnemonic/LR/SR to the word plus an illegal flag. It is reusable by the emulator test host.

## Test plan
- START, then ADD LR=2 SR=3 with LAST → MEM_WE one cycle at addr 0, data 10111_010_011. DONE=1 next cycle, ERR=0, CPU_HOLD falls.
- 16 back-to-back legal JMP words (ADDR_W=4) with IN_VALID held high → addresses 0..15, IN_READY toggles 1/0. A 17th word gives ERR_CODE=2 with no write.
- AND with LR=1 → no MEM_WE, ERR_CODE=1, DONE asserted 1 cycle after acceptance.
- Mnemonic 9 → ERR_CODE=1. A following START clears ERR and the address restarts at 0.
- nRST asserted in the WRITE cycle → MEM_WE drops immediately and all outputs are 0. After release, START works normally.
- PROG_VERIFY_EN with the memory model corrupting bit 0 at addr 2 → the third word gives ERR_CODE=3. Addresses 0 and 1 verify clean.
